qspi_flash_emu: RTL

QSPI_FLASH_EMU -- requirements
Module: qspi_flash_emu

---
 rtl/qspi_pkg.sv | 20 ++
 rtl/qspi_delay_line.sv | 40 ++++
 rtl/qspi_flash_emu.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash emulator.
//   state_e        : transaction state machine encoding
//   CmdQuadRead    : the only supported command (quad I/O fast read)
//   ContModeNibble : upper mode nibble that arms continuous-read mode
package qspi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StMode,
    StDummy,
    StData,
    StIgnore
  } state_e;

  localparam logic [7:0] CmdQuadRead    = 8'hEB;
  localparam logic [3:0] ContModeNibble = 4'hA;

endpackage

// File: rtl/qspi_delay_line.sv
// Programmable output delay line.
//   clk, rst : system clock, synchronous active-high reset
//   flush    : clears every stage (used when chip select rises)
//   lat      : delay selection in clk cycles, 0..MAX_LATENCY
//   din      : undelayed input word
//   dout     : din delayed by lat cycles (lat = 0 passes din straight through)
module qspi_delay_line #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned MAX_LATENCY = 5,
  parameter int unsigned LW          = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [LW-1:0]    lat,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned Depth = (MAX_LATENCY > 0) ? MAX_LATENCY : 1;

  logic [WIDTH-1:0] stage [Depth];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < Depth; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    dout = din;
    for (int i = 1; i <= Depth; i++) begin
      if (int'(lat) == i) dout = stage[i-1];
    end
  end

endmodule

// File: rtl/qspi_flash_emu.sv
// QSPI flash emulator supporting the 0xEB quad I/O read with continuous-read mode.
// The QSPI bus is oversampled by clk; all inputs are registered once and edges are
// detected against the previous sample.
//   clk, rst            : system clock, synchronous active-high reset
//   qspi_clk_i          : QSPI serial clock (period >= 4 clk)
//   qspi_cs_n_i         : chip select, active low
//   qspi_d_i / qspi_d_o : host-to-device lanes / device-to-host nibble
//   qspi_d_oe           : high while qspi_d_o is driven
//   latency_i           : extra output delay, clamped to MAX_LATENCY, sampled at cs fall
//   mem_rd_o/mem_addr_o : one-cycle backing-store read strobe and byte address
//   mem_data_i          : read data, valid the cycle after mem_rd_o
//   cont_mode_o         : continuous-read mode armed (next transaction skips command)
//   err_o               : one-cycle pulse on an unsupported command
module qspi_flash_emu import qspi_pkg::*; #(
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned DUMMY_NIBBLES = 4,
  parameter int unsigned MAX_LATENCY   = 5,
  parameter int unsigned LW            = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 qspi_clk_i,
  input  logic                 qspi_cs_n_i,
  input  logic [3:0]           qspi_d_i,
  output logic [3:0]           qspi_d_o,
  output logic                 qspi_d_oe,
  input  logic [LW-1:0]        latency_i,
  output logic                 mem_rd_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  input  logic [7:0]           mem_data_i,
  output logic                 cont_mode_o,
  output logic                 err_o
);

  localparam int unsigned AddrNibbles = ADDR_BITS / 4;
  localparam logic [LW-1:0] MaxLat = LW'(MAX_LATENCY);

  // Input sampling and edge detection
  logic       clk_r, clk_p, cs_r, cs_p;
  logic [3:0] d_r;
  logic       clk_rise, clk_fall, cs_rise, cs_fall;

  // Reset loads both samples from the live pins so a cs already low after reset
  // does not look like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_r <= qspi_clk_i;
      clk_p <= qspi_clk_i;
      cs_r  <= qspi_cs_n_i;
      cs_p  <= qspi_cs_n_i;
      d_r   <= qspi_d_i;
    end else begin
      clk_r <= qspi_clk_i;
      clk_p <= clk_r;
      cs_r  <= qspi_cs_n_i;
      cs_p  <= cs_r;
      d_r   <= qspi_d_i;
    end
  end

  assign clk_rise = clk_r & ~clk_p;
  assign clk_fall = ~clk_r & clk_p;
  assign cs_rise  = cs_r & ~cs_p;
  assign cs_fall  = ~cs_r & cs_p;

  // Transaction state machine
  state_e               state;
  logic [7:0]           cnt;
  logic [6:0]           cmd;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [3:0]           mode_hi;
  logic [LW-1:0]        lat;
  logic                 rd_pend;
  logic [7:0]           next_byte;
  logic [3:0]           low_nib;
  logic                 hi_phase;
  logic                 out_en;
  logic [3:0]           out_nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      cmd         <= '0;
      addr_sh     <= '0;
      mode_hi     <= '0;
      lat         <= '0;
      rd_pend     <= 1'b0;
      next_byte   <= '0;
      low_nib     <= '0;
      hi_phase    <= 1'b1;
      out_en      <= 1'b0;
      out_nib     <= '0;
      mem_rd_o    <= 1'b0;
      mem_addr_o  <= '0;
      cont_mode_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mem_rd_o <= 1'b0;
      err_o    <= 1'b0;
      rd_pend  <= mem_rd_o;
      if (rd_pend) next_byte <= mem_data_i;

      if (cs_rise) begin
        state   <= StIdle;
        out_en  <= 1'b0;
        out_nib <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (cs_fall) begin
              state <= cont_mode_o ? StAddr : StCmd;
              cnt   <= '0;
              lat   <= (latency_i > MaxLat) ? MaxLat : latency_i;
            end
          end
          StCmd: begin
            if (clk_rise) begin
              cmd <= {cmd[5:0], d_r[0]};
              cnt <= cnt + 8'd1;
              if (cnt == 8'd7) begin
                cnt <= '0;
                if ({cmd, d_r[0]} == CmdQuadRead) begin
                  state <= StAddr;
                end else begin
                  state       <= StIgnore;
                  err_o       <= 1'b1;
                  cont_mode_o <= 1'b0;
                end
              end
            end
          end
          StAddr: begin
            if (clk_rise) begin
              addr_sh <= {addr_sh[ADDR_BITS-5:0], d_r};
              cnt     <= cnt + 8'd1;
              if (cnt == 8'(AddrNibbles - 1)) begin
                cnt        <= '0;
                mem_rd_o   <= 1'b1;
                mem_addr_o <= {addr_sh[ADDR_BITS-5:0], d_r};
                state      <= StMode;
              end
            end
          end
          StMode: begin
            if (clk_rise) begin
              cnt <= cnt + 8'd1;
              if (cnt == 8'd0) begin
                mode_hi <= d_r;
              end else begin
                cnt         <= '0;
                cont_mode_o <= (mode_hi == ContModeNibble);
                hi_phase    <= 1'b1;
                state       <= (DUMMY_NIBBLES == 0) ? StData : StDummy;
              end
            end
          end
          StDummy: begin
            if (clk_rise) begin
              cnt <= cnt + 8'd1;
              if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
                cnt      <= '0;
                hi_phase <= 1'b1;
                state    <= StData;
              end
            end
          end
          StData: begin
            if (clk_fall) begin
              out_en   <= 1'b1;
              hi_phase <= ~hi_phase;
              if (hi_phase) begin
                // Keep the low nibble aside: the prefetch issued here overwrites next_byte.
                out_nib    <= next_byte[7:4];
                low_nib    <= next_byte[3:0];
                mem_rd_o   <= 1'b1;
                mem_addr_o <= mem_addr_o + ADDR_BITS'(1);
              end else begin
                out_nib <= low_nib;
              end
            end
          end
          StIgnore: state <= StIgnore;
          default:  state <= StIdle;
        endcase
      end
    end
  end

  // Output delay: enable and nibble travel together so they stay aligned.
  logic [4:0] dly_out;

  qspi_delay_line #(
    .WIDTH       (5),
    .MAX_LATENCY (MAX_LATENCY),
    .LW          (LW)
  ) u_delay_line (
    .clk   (clk),
    .rst   (rst),
    .flush (cs_rise),
    .lat   (lat),
    .din   ({out_en, out_nib}),
    .dout  (dly_out)
  );

  assign qspi_d_oe = dly_out[4];
  assign qspi_d_o  = dly_out[3:0] & {4{dly_out[4]}};

endmodule
